// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host receiver: error codes, FSM states and
// the odd-parity helper.
package ps2_pkg;

    localparam int PS2_DATA_BITS = 8;

    localparam logic [1:0] PS2_ERR_NONE    = 2'd0;
    localparam logic [1:0] PS2_ERR_PARITY  = 2'd1;
    localparam logic [1:0] PS2_ERR_FRAME   = 2'd2;
    localparam logic [1:0] PS2_ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    // PS/2 parity bit makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~(^d);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus glitch filter for one PS/2 line; emits a one-cycle pulse
// on the cycle the filtered level first reads 0 after being 1.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_in,
    output logic fall
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_s;
    logic                   level_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   settled;

    assign line_s  = sync_q[SYNC_STAGES-1];
    assign settled = (cnt_q == CNT_W'(FILTER_LEN - 1));

    // cnt_q counts consecutive samples disagreeing with the filtered level
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
            fall   <= 1'b0;
            if (line_s == level_q) begin
                cnt_q <= '0;
            end else if (settled) begin
                level_q <= line_s;
                cnt_q   <= '0;
                fall    <= level_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_rx.sv
// Receive-only PS/2 host: deframes 11-bit frames into a one-entry valid/ready
// buffer. Define PS2_HOST_RX_INHIBIT_EN to hold the device clock low while a byte waits.
module ps2_host_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_in_clk,
    input  logic       ps2_in_data,
    output logic       ps2_out_clk,
    output logic       ps2_out_data,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_error,
    output logic [1:0] rx_err_code,
    output logic       rx_overrun
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int BIT_W = $clog2(PS2_DATA_BITS);

    logic                     fall_p0;
    logic [SYNC_STAGES-1:0]   data_sync_q;
    logic                     data_p0;

    ps2_state_t               state, state_next;
    logic [PS2_DATA_BITS-1:0] shift_q;
    logic [BIT_W-1:0]         bitcnt_q;
    logic [TO_W-1:0]          to_cnt_q;
    logic                     par_err_q;

    logic                     timeout_hit;
    logic                     frame_good;
    logic                     err_hit;
    logic [1:0]               err_code_d;

    // Front end: filtered clock edge and synchronised data, aligned in time
    ps2_line_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .line_in (ps2_in_clk),
        .fall    (fall_p0)
    );

    always_ff @(posedge clk) begin
        if (reset) data_sync_q <= '1;
        else       data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_in_data};
    end

    assign data_p0 = data_sync_q[SYNC_STAGES-1];

    // Deframing FSM
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (fall_p0 && !data_p0) state_next = ST_DATA;
            ST_DATA: begin
                if (timeout_hit)
                    state_next = ST_IDLE;
                else if (fall_p0 && bitcnt_q == BIT_W'(PS2_DATA_BITS - 1))
                    state_next = ST_PARITY;
            end
            ST_PARITY: begin
                if (timeout_hit)  state_next = ST_IDLE;
                else if (fall_p0) state_next = ST_STOP;
            end
            ST_STOP:   if (timeout_hit || fall_p0) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        timeout_hit = 1'b0;
        frame_good  = 1'b0;
        err_hit     = 1'b0;
        err_code_d  = PS2_ERR_NONE;
        if (state != ST_IDLE && !fall_p0 && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_hit = 1'b1;
            err_hit     = 1'b1;
            err_code_d  = PS2_ERR_TIMEOUT;
        end
        if (state == ST_STOP && fall_p0) begin
            if (par_err_q) begin
                err_hit    = 1'b1;
                err_code_d = PS2_ERR_PARITY;
            end else if (!data_p0) begin
                err_hit    = 1'b1;
                err_code_d = PS2_ERR_FRAME;
            end else begin
                frame_good = 1'b1;
            end
        end
    end

    // to_cnt_q holds the number of cycles elapsed since the last accepted edge
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q   <= '0;
            bitcnt_q  <= '0;
            to_cnt_q  <= '0;
            par_err_q <= 1'b0;
        end else begin
            if (state_next == ST_IDLE) to_cnt_q <= '0;
            else if (fall_p0)          to_cnt_q <= TO_W'(1);
            else                       to_cnt_q <= to_cnt_q + TO_W'(1);

            if (state == ST_IDLE) begin
                bitcnt_q  <= '0;
                par_err_q <= 1'b0;
            end
            if (state == ST_DATA && fall_p0) begin
                shift_q  <= {data_p0, shift_q[PS2_DATA_BITS-1:1]};
                bitcnt_q <= bitcnt_q + BIT_W'(1);
            end
            if (state == ST_PARITY && fall_p0)
                par_err_q <= (data_p0 != odd_parity(shift_q));
        end
    end

    // Output stage: one-entry buffer and status pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            rx_error    <= 1'b0;
            rx_err_code <= PS2_ERR_NONE;
            rx_overrun  <= 1'b0;
        end else begin
            rx_error    <= err_hit;
            rx_err_code <= err_code_d;
            rx_overrun  <= frame_good && rx_valid && !rx_ready;
            if (frame_good && (!rx_valid || rx_ready)) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign ps2_out_data = 1'b1;

`ifdef PS2_HOST_RX_INHIBIT_EN
    // Registered so the open-drain clock request never glitches
    always_ff @(posedge clk) begin
        if (reset) ps2_out_clk <= 1'b1;
        else       ps2_out_clk <= !(rx_valid && state == ST_IDLE);
    end
`else
    assign ps2_out_clk = 1'b1;
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Bench for ps2_host_rx: directed table, hand-written corner sequences and
// randomized frames checked against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_ps2_host_rx;
    import ps2_pkg::*;

    localparam int SYNC_STAGES    = 2;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 5000;
    localparam int HALF_FAST      = 25;
    localparam int HALF_SLOW      = 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_in_clk;
    logic       ps2_in_data;
    logic       rx_ready;
    logic       ps2_out_clk;
    logic       ps2_out_data;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_error;
    logic [1:0] rx_err_code;
    logic       rx_overrun;

    always #10 clk = ~clk;

    ps2_host_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_in_clk   (ps2_in_clk),
        .ps2_in_data  (ps2_in_data),
        .ps2_out_clk  (ps2_out_clk),
        .ps2_out_data (ps2_out_data),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .rx_error     (rx_error),
        .rx_err_code  (rx_err_code),
        .rx_overrun   (rx_overrun)
    );

    int vectors = 0;
    int miscompares = 0;

    // Event monitor, sampled on the falling clock edge
    int         cyc = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    int         both_cnt = 0;
    int         err_cyc = 0;
    int         last_fall_cyc = 0;
    logic [1:0] last_code = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_error) begin
            err_cnt   <= err_cnt + 1;
            last_code <= rx_err_code;
            err_cyc   <= cyc;
        end
        if (rx_overrun)             ovr_cnt  <= ovr_cnt + 1;
        if (rx_error && rx_overrun) both_cnt <= both_cnt + 1;
    end

    // Frame-level reference model
    int         exp_err = 0;
    int         exp_ovr = 0;
    logic [1:0] exp_code = 2'd0;
    logic       exp_valid = 1'b0;
    logic [7:0] exp_data = 8'h00;

    task automatic model_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok);
        if (!par_ok) begin
            exp_err++;
            exp_code = PS2_ERR_PARITY;
        end else if (!stop_ok) begin
            exp_err++;
            exp_code = PS2_ERR_FRAME;
        end else if (exp_valid) begin
            exp_ovr++;
        end else begin
            exp_valid = 1'b1;
            exp_data  = d;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_model(input string name);
        check({name, " error count"}, err_cnt, exp_err);
        if (exp_err > 0) check({name, " error code"}, last_code, exp_code);
        check({name, " overrun count"}, ovr_cnt, exp_ovr);
        check({name, " rx_valid"}, rx_valid, exp_valid);
        check({name, " rx_data"}, rx_data, exp_data);
    endtask

    task automatic accept(input string name);
        check({name, " valid before accept"}, rx_valid, exp_valid);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check({name, " valid after accept"}, rx_valid, 1'b0);
        exp_valid = 1'b0;
    endtask

    task automatic drive_bit(input bit b, input int half, input bit glitch);
        ps2_in_data = b;
        if (glitch) begin
            repeat (half / 2) @(negedge clk);
            ps2_in_clk = 1'b0;
            repeat (3) @(negedge clk);
            ps2_in_clk = 1'b1;
            repeat (half - half / 2 - 3) @(negedge clk);
        end else begin
            repeat (half) @(negedge clk);
        end
        ps2_in_clk    = 1'b0;
        last_fall_cyc = cyc;
        repeat (half) @(negedge clk);
        ps2_in_clk = 1'b1;
    endtask

    // Sends the first nbits of a frame (start, 8 data LSB first, parity, stop)
    task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop_ok,
                              input int half, input int glitch_at, input int nbits);
        logic [10:0] f;
        f = {stop_ok, (~^d) ^ !par_ok, d, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(f[i], half, i == glitch_at);
        ps2_in_data = 1'b1;
        repeat (SYNC_STAGES + FILTER_LEN + 4) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         par_ok;
        bit         stop_ok;
        logic [1:0] req_code;
        logic       req_valid;
        logic [7:0] req_data;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int err0;
        bit hold_ok;
        logic [7:0] rd;
        int kind;

        tbl[0] = '{8'hF0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h00};
        tbl[1] = '{8'h55, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00};
        tbl[2] = '{8'hAA, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00};
        tbl[3] = '{8'hAA, 1'b1, 1'b1, 2'd0, 1'b1, 8'hAA};
        tbl[4] = '{8'h00, 1'b1, 1'b1, 2'd0, 1'b1, 8'h00};
        tbl[5] = '{8'hFF, 1'b1, 1'b1, 2'd0, 1'b1, 8'hFF};

        reset       = 1'b1;
        ps2_in_clk  = 1'b1;
        ps2_in_data = 1'b1;
        rx_ready    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rx_valid", rx_valid, 1'b0);
        check("reset rx_data", rx_data, 8'h00);
        check("reset rx_error", rx_error, 1'b0);
        check("reset rx_err_code", rx_err_code, 2'd0);
        check("reset rx_overrun", rx_overrun, 1'b0);
        check("reset ps2_out_clk", ps2_out_clk, 1'b1);
        check("reset ps2_out_data", ps2_out_data, 1'b1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0x1C at 40 us half-period, held then accepted
        send_frame(8'h1C, 1'b1, 1'b1, HALF_SLOW, -1, 11);
        model_frame(8'h1C, 1'b1, 1'b1);
        check_model("slow 1C");
        hold_ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!rx_valid || rx_data != 8'h1C) hold_ok = 1'b0;
        end
        check("1C held 1000 cycles", hold_ok, 1'b1);
        accept("slow 1C");

        for (int i = 0; i < 6; i++) begin
            err0 = err_cnt;
            send_frame(tbl[i].data, tbl[i].par_ok, tbl[i].stop_ok, HALF_FAST, -1, 11);
            model_frame(tbl[i].data, tbl[i].par_ok, tbl[i].stop_ok);
            check($sformatf("table %0d error pulses", i), err_cnt - err0, (tbl[i].req_code != 2'd0) ? 1 : 0);
            if (tbl[i].req_code != 2'd0) check($sformatf("table %0d code", i), last_code, tbl[i].req_code);
            check($sformatf("table %0d rx_valid", i), rx_valid, tbl[i].req_valid);
            if (tbl[i].req_valid) begin
                check($sformatf("table %0d rx_data", i), rx_data, tbl[i].req_data);
                accept($sformatf("table %0d", i));
            end
        end

        // Clock stops after start + 5 data bits
        send_frame(8'h3B, 1'b1, 1'b1, HALF_FAST, -1, 6);
        repeat (6000) @(negedge clk);
        exp_err++;
        exp_code = PS2_ERR_TIMEOUT;
        check_model("timeout");
        check("timeout latency", err_cyc - last_fall_cyc, SYNC_STAGES + FILTER_LEN + TIMEOUT_CYCLES);
        send_frame(8'hAA, 1'b1, 1'b1, HALF_FAST, -1, 11);
        model_frame(8'hAA, 1'b1, 1'b1);
        check_model("AA after timeout");
        accept("AA after timeout");

        // Overrun: second good frame while first is unconsumed
        send_frame(8'h1C, 1'b1, 1'b1, HALF_FAST, -1, 11);
        model_frame(8'h1C, 1'b1, 1'b1);
        check_model("overrun first");
`ifdef PS2_HOST_RX_INHIBIT_EN
        check("inhibit while pending", ps2_out_clk, 1'b0);
`else
        check("clock released while pending", ps2_out_clk, 1'b1);
`endif
        send_frame(8'h32, 1'b1, 1'b1, HALF_FAST, -1, 11);
        model_frame(8'h32, 1'b1, 1'b1);
        check_model("overrun second");
        accept("overrun");
        @(negedge clk);
        check("clock released after accept", ps2_out_clk, 1'b1);

        // Glitches in IDLE (data low) and mid-frame
        ps2_in_data = 1'b0;
        repeat (5) @(negedge clk);
        ps2_in_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_in_clk = 1'b1;
        repeat (40) @(negedge clk);
        ps2_in_data = 1'b1;
        repeat (20) @(negedge clk);
        check_model("glitch idle");
        send_frame(8'h5A, 1'b1, 1'b1, HALF_FAST, 4, 11);
        model_frame(8'h5A, 1'b1, 1'b1);
        check_model("glitch data");
        accept("glitch data");

        // Reset mid-frame
        send_frame(8'h77, 1'b1, 1'b1, HALF_FAST, -1, 4);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        check_model("mid-frame reset");
        send_frame(8'h1C, 1'b1, 1'b1, HALF_FAST, -1, 11);
        model_frame(8'h1C, 1'b1, 1'b1);
        check_model("1C after reset");
        accept("1C after reset");

        // Randomized frames
        for (int i = 0; i < 10; i++) begin
            rd   = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 5);
            send_frame(rd, kind != 0, kind != 1, HALF_FAST, -1, 11);
            model_frame(rd, kind != 0, kind != 1);
            check_model($sformatf("random %0d", i));
            if ($urandom_range(0, 1) == 1) accept($sformatf("random %0d", i));
        end

        check("error and overrun together", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
- Receive-only PS/2 host front end on the 50 MHz system clock, sitting directly downstream of the board-level open-drain PS/2 pads.
- Consumes the pad-level inputs (ps2_in_clk, ps2_in_data) and returns release/drive requests (ps2_out_clk, ps2_out_data; 1 = release, 0 = pull low).
- Synchronises and glitch-filters the device clock, deframes 11-bit PS/2 frames and checks parity, stop bit and inter-edge timeout.
- Presents each received byte through a one-entry valid/ready buffer to keyboard/mouse logic.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on each PS/2 input (minimum 2).
- FILTER_LEN, 8: consecutive identical samples required before the filtered PS/2 clock changes level (1..255).
- TIMEOUT_CYCLES, 5000: maximum system clocks between filtered falling edges inside a frame (100 us at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- ps2_in_clk  in  1  PS/2 clock pad level (asynchronous)
- ps2_in_data  in  1  PS/2 data pad level (asynchronous)
- ps2_out_clk  out  1  1 = release clock line, 0 = pull low
- ps2_out_data  out  1  constant 1 (receive-only)
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_data  out  8  received byte
- rx_ready  in  1  consumer accepts byte when rx_valid && rx_ready
- rx_error  out  1  one-cycle pulse: frame rejected
- rx_err_code  out  2  reason, valid while rx_error=1: 1 parity, 2 framing (stop=0), 3 timeout
- rx_overrun  out  1  one-cycle pulse: good frame dropped because the buffer was full

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values:
  - rx_valid=0, rx_data=0x00, rx_error=0, rx_err_code=0, rx_overrun=0, ps2_out_clk=1, ps2_out_data=1.
  - FSM returns to IDLE; shift register, bit counter and timeout counter clear.
  - Filtered clock level resets to 1.
- Front end:
  - Each input passes through SYNC_STAGES flops.
  - The filtered clock takes the synchronised value only after FILTER_LEN consecutive equal samples.
  - A falling edge is the filtered level going 1->0. Data is sampled from the synchronised data line on that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 go to DATA and clear bitcnt. On an edge with data=1 stay in IDLE; this is not an error.
  - DATA: shift data in LSB first. After the 8th bit go to PARITY.
  - PARITY: compare data against the odd parity of the 8 bits (XOR of the data bits, inverted). Record a mismatch, then go to STOP.
  - STOP: evaluate the stop bit, then return to IDLE.
    - Stop=0: error code 2.
    - Parity mismatch recorded: error code 1. Parity takes priority over framing.
    - Otherwise the frame is good.
- Timeout:
  - The counter runs in DATA/PARITY/STOP and clears on every edge.
  - If it reaches TIMEOUT_CYCLES: rx_error=1, rx_err_code=3, FSM goes to IDLE and the partial frame is discarded.
- Output buffer:
  - A good frame loads rx_data and sets rx_valid on the cycle after the stop-bit edge.
  - rx_valid holds until a cycle with rx_ready=1, and clears on the following cycle.
  - Accept and load on the same cycle: the new byte loads and rx_valid stays 1.
  - A good frame completing while rx_valid=1 and rx_ready=0 is dropped: rx_overrun pulses and rx_data is unchanged.
  - Error frames never touch rx_valid or rx_data.
- rx_error and rx_overrun are single-cycle pulses and are never both asserted.
- Reset asserted mid-frame aborts the frame without any error pulse.

Optional Feature:
- Macro: PS2_HOST_RX_INHIBIT_EN.
- Defined: ps2_out_clk=0 whenever rx_valid=1 and the FSM is in IDLE. This inhibits the device until the byte is consumed, and ps2_out_clk returns to 1 on the cycle after rx_valid clears. An in-progress frame is never inhibited.
- Undefined: ps2_out_clk is constant 1, and overrun behaviour is as above.

Decomposition:
- Package ps2_pkg holds:
  - err-code constants: PS2_ERR_NONE=0, PS2_ERR_PARITY=1, PS2_ERR_FRAME=2, PS2_ERR_TIMEOUT=3;
  - the FSM state enum;
  - PS2_DATA_BITS=8.
- Sub-module ps2_line_filter (synchroniser, glitch filter, falling-edge pulse) is instanced for the clock line. The data line uses the synchroniser only.

Test Plan:
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) at 40 us half-period -> rx_valid=1, rx_data=0x1C; held 1000 cycles with rx_ready=0; cleared the cycle after rx_ready=1.
- Frame 0xF0 with parity bit 0 (correct is 1) -> rx_error pulse with rx_err_code=1; rx_valid stays 0.
- Frame 0x55 with stop bit 0 -> rx_err_code=2. Frame 0xAA with parity bit 0 and stop bit 0 -> rx_err_code=1.
- Stop the clock for 6000 cycles after 5 data bits -> rx_err_code=3 exactly TIMEOUT_CYCLES after the last edge; a following 0xAA frame is received correctly.
- 0x1C then 0x32 with rx_ready=0 -> rx_data stays 0x1C and rx_overrun pulses once. With PS2_HOST_RX_INHIBIT_EN: ps2_out_clk=0 after 0x1C and returns to 1 after accept.
- Clock glitch (3-cycle low pulse) during IDLE and DATA -> no edge, no state change. reset asserted mid-frame -> IDLE, no pulses; the next 0x1C frame is received correctly.
